// File: rtl/bel_cmul_pipe.sv
// -----------------------------------------------------------------------------
// bel_cmul_pipe
//
// Pipelined complex multiplier for the FFT twiddle stage: x = a * w, or
// x = a * conj(w) when conj_i is set (inverse transform). The twiddle w is
// Q1.(tw_width-1); the result is rounded half-up back to the sample scale.
// Three register stages (capture, products, sum/round/limit) advance together
// under a single enable, so a stalled output freezes the whole pipeline.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            synchronous reset, active-high
//   a_re_i, a_im_i   sample (word_width, two's complement)
//   w_re_i, w_im_i   twiddle (tw_width, Q1.(tw_width-1))
//   conj_i           1 = multiply by conj(w)
//   valid_i/ready_o  input handshake (ready_o = !valid_o || ready_i)
//   x_re_o, x_im_o   product (word_width)
//   valid_o/ready_i  output handshake
//
// Configuration macro
//   BEL_CMUL_SATURATE_EN  defined: clamp the rounded result to word_width;
//                         undefined: keep the low word_width bits (wrap).
// -----------------------------------------------------------------------------
module bel_cmul_pipe #(
  parameter int word_width = 16,
  parameter int tw_width   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [word_width-1:0] a_re_i,
  input  logic [word_width-1:0] a_im_i,
  input  logic [tw_width-1:0]   w_re_i,
  input  logic [tw_width-1:0]   w_im_i,
  input  logic                  conj_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [word_width-1:0] x_re_o,
  output logic [word_width-1:0] x_im_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int P_W = word_width + tw_width;   // product width
  localparam int S_W = P_W + 1;                 // sum width
  localparam int R_W = word_width + 2;          // rounded result before limiting

  // Half an LSB of the output scale, added before dropping tw_width-1 bits.
  localparam logic signed [S_W-1:0] ROUND_C = {{(S_W-1){1'b0}}, 1'b1} << (tw_width - 2);

  // Stage 1: captured operands
  logic [word_width-1:0] a_re_q, a_im_q;
  logic [tw_width-1:0]   w_re_q, w_im_q;
  logic                  conj1_q, v1_q;

  // Stage 2: partial products
  logic signed [P_W-1:0] pp_rr_q, pp_ii_q, pp_ri_q, pp_ir_q;
  logic signed [P_W-1:0] pp_rr_d, pp_ii_d, pp_ri_d, pp_ir_d;
  logic                  conj2_q, v2_q;

  // Stage 3: limited result
  logic [word_width-1:0] x_re_q, x_im_q, x_re_d, x_im_d;
  logic                  v3_q;

  logic                  en_s;
  logic signed [P_W-1:0] a_re_x_s, a_im_x_s, w_re_x_s, w_im_x_s;
  logic signed [S_W-1:0] sum_re_s, sum_im_s, rnd_re_s, rnd_im_s;
  logic [R_W-1:0]        r_re_s, r_im_s;
  logic                  unused_s;

  assign en_s    = ~v3_q | ready_i;
  assign ready_o = en_s;
  assign valid_o = v3_q;
  assign x_re_o  = x_re_q;
  assign x_im_o  = x_im_q;

`ifdef BEL_CMUL_SATURATE_EN
  // Clamp an R_W-bit value to the word_width two's-complement range.
  function automatic logic [word_width-1:0] sat_word(input logic [R_W-1:0] r);
    logic [word_width-1:0] res;
    if (r[R_W-1:word_width-1] == {3{r[R_W-1]}}) begin
      res = r[word_width-1:0];
    end else if (r[R_W-1]) begin
      res = {1'b1, {(word_width-1){1'b0}}};
    end else begin
      res = {1'b0, {(word_width-1){1'b1}}};
    end
    return res;
  endfunction
`endif

  // Stage 2 next-state: sign-extend operands to product width, then multiply.
  always_comb begin
    a_re_x_s = {{tw_width{a_re_q[word_width-1]}}, a_re_q};
    a_im_x_s = {{tw_width{a_im_q[word_width-1]}}, a_im_q};
    w_re_x_s = {{word_width{w_re_q[tw_width-1]}}, w_re_q};
    w_im_x_s = {{word_width{w_im_q[tw_width-1]}}, w_im_q};
    pp_rr_d  = a_re_x_s * w_re_x_s;
    pp_ii_d  = a_im_x_s * w_im_x_s;
    pp_ri_d  = a_re_x_s * w_im_x_s;
    pp_ir_d  = a_im_x_s * w_re_x_s;
  end

  // Stage 3 next-state: combine products, round half-up, limit to word_width.
  always_comb begin
    // Conjugation flips the sign of the w_im terms instead of negating w_im,
    // so the most negative twiddle value stays exact.
    if (conj2_q) begin
      sum_re_s = {pp_rr_q[P_W-1], pp_rr_q} + {pp_ii_q[P_W-1], pp_ii_q};
      sum_im_s = {pp_ir_q[P_W-1], pp_ir_q} - {pp_ri_q[P_W-1], pp_ri_q};
    end else begin
      sum_re_s = {pp_rr_q[P_W-1], pp_rr_q} - {pp_ii_q[P_W-1], pp_ii_q};
      sum_im_s = {pp_ir_q[P_W-1], pp_ir_q} + {pp_ri_q[P_W-1], pp_ri_q};
    end
    rnd_re_s = sum_re_s + ROUND_C;
    rnd_im_s = sum_im_s + ROUND_C;
    // Taking the top bits is the arithmetic shift by tw_width-1.
    r_re_s   = rnd_re_s[S_W-1:tw_width-1];
    r_im_s   = rnd_im_s[S_W-1:tw_width-1];
`ifdef BEL_CMUL_SATURATE_EN
    x_re_d   = sat_word(r_re_s);
    x_im_d   = sat_word(r_im_s);
    unused_s = ^{rnd_re_s[tw_width-2:0], rnd_im_s[tw_width-2:0]};
`else
    x_re_d   = r_re_s[word_width-1:0];
    x_im_d   = r_im_s[word_width-1:0];
    unused_s = ^{rnd_re_s[tw_width-2:0], rnd_im_s[tw_width-2:0],
                 r_re_s[R_W-1:word_width], r_im_s[R_W-1:word_width]};
`endif
  end

  // Pipeline registers: clear on reset, shift together when enabled, else hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_re_q  <= '0;
      a_im_q  <= '0;
      w_re_q  <= '0;
      w_im_q  <= '0;
      conj1_q <= 1'b0;
      v1_q    <= 1'b0;
      pp_rr_q <= '0;
      pp_ii_q <= '0;
      pp_ri_q <= '0;
      pp_ir_q <= '0;
      conj2_q <= 1'b0;
      v2_q    <= 1'b0;
      x_re_q  <= '0;
      x_im_q  <= '0;
      v3_q    <= 1'b0;
    end else if (en_s) begin
      a_re_q  <= a_re_i;
      a_im_q  <= a_im_i;
      w_re_q  <= w_re_i;
      w_im_q  <= w_im_i;
      conj1_q <= conj_i;
      v1_q    <= valid_i;
      pp_rr_q <= pp_rr_d;
      pp_ii_q <= pp_ii_d;
      pp_ri_q <= pp_ri_d;
      pp_ir_q <= pp_ir_d;
      conj2_q <= conj1_q;
      v2_q    <= v1_q;
      x_re_q  <= x_re_d;
      x_im_q  <= x_im_d;
      v3_q    <= v2_q;
    end
  end

endmodule

// File: tb/tb_bel_cmul_pipe.sv
// -----------------------------------------------------------------------------
// tb_bel_cmul_pipe
//
// Directed bench for bel_cmul_pipe (word_width = tw_width = 16). Inputs are
// driven on the falling edge; outputs are sampled on the falling edge (or 1
// time unit later where a combinational output depends on a just-driven input).
// -----------------------------------------------------------------------------
module tb_bel_cmul_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] a_re_i, a_im_i, w_re_i, w_im_i;
  logic        conj_i, valid_i, ready_o;
  logic [15:0] x_re_o, x_im_o;
  logic        valid_o, ready_i;

  int checks   = 0;
  int failures = 0;

  bel_cmul_pipe #(.word_width(16), .tw_width(16)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .a_re_i  (a_re_i),
    .a_im_i  (a_im_i),
    .w_re_i  (w_re_i),
    .w_im_i  (w_im_i),
    .conj_i  (conj_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .x_re_o  (x_re_o),
    .x_im_o  (x_im_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Round half-up from Q15 scale, then limit to 16 bits.
  function automatic int lim(input longint s);
    longint r;
    logic signed [15:0] t;
    r = (s + 64'sd16384) >>> 15;
`ifdef BEL_CMUL_SATURATE_EN
    if (r > 64'sd32767) r = 64'sd32767;
    else if (r < -64'sd32768) r = -64'sd32768;
    t = r[15:0];
`else
    t = r[15:0];
`endif
    return int'(t);
  endfunction

  task automatic model(input int ar, input int ai, input int wr, input int wi,
                       input bit cj, output int xr, output int xi);
    longint rr, ii, ri, ir;
    rr = longint'(ar) * longint'(wr);
    ii = longint'(ai) * longint'(wi);
    ri = longint'(ar) * longint'(wi);
    ir = longint'(ai) * longint'(wr);
    xr = cj ? lim(rr + ii) : lim(rr - ii);
    xi = cj ? lim(ir - ri) : lim(ir + ri);
  endtask

  task automatic drive(input int ar, input int ai, input int wr, input int wi,
                       input bit cj, input bit v);
    a_re_i  = ar[15:0];
    a_im_i  = ai[15:0];
    w_re_i  = wr[15:0];
    w_im_i  = wi[15:0];
    conj_i  = cj;
    valid_i = v;
  endtask

  // Single beat through an empty pipeline with ready_i high: checks latency and value.
  task automatic send_check(input string tag, input int ar, input int ai, input int wr,
                            input int wi, input bit cj, input int er, input int ei);
    @(negedge clk_i);
    ready_i = 1'b1;
    drive(ar, ai, wr, wi, cj, 1'b1);
    @(negedge clk_i);
    valid_i = 1'b0;
    check({tag, "_lat1"}, int'(valid_o), 0);
    @(negedge clk_i);
    check({tag, "_lat2"}, int'(valid_o), 0);
    @(negedge clk_i);
    check({tag, "_lat3"}, int'(valid_o), 1);
    check({tag, "_re"}, int'($signed(x_re_o)), er);
    check({tag, "_im"}, int'($signed(x_im_o)), ei);
    @(negedge clk_i);
    check({tag, "_gone"}, int'(valid_o), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat[4];
    int vr[8], vi[8], wr[8], wi[8], er[8], ei[8];
    bit vc[8];
    int sent, recv, hold_re, hold_im;
    bit hold_v;

    rst_i   = 1'b1;
    ready_i = 1'b0;
    drive(0, 0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst_valid_o", int'(valid_o), 0);
    check("rst_x_re", int'($signed(x_re_o)), 0);
    check("rst_x_im", int'($signed(x_im_o)), 0);
    check("rst_ready_o", int'(ready_o), 1);

    send_check("scale", 1000, 0, 16384, 0, 1'b0, 500, 0);
    send_check("cmul", 1000, 2000, 0, 16384, 1'b0, -1000, 500);
    send_check("cconj", 1000, 2000, 0, 16384, 1'b1, 1000, -500);
    send_check("round", 3, -3, 16384, 0, 1'b0, 2, -1);
`ifdef BEL_CMUL_SATURATE_EN
    send_check("corner", -32768, -32768, -32768, -32768, 1'b0, 0, 32767);
`else
    send_check("corner", -32768, -32768, -32768, -32768, 1'b0, 0, 0);
`endif

    // Back-pressure stream: 8 beats, ready_i pattern 1,0,0,1 repeating.
    pat = '{1, 0, 0, 1};
    for (int i = 0; i < 8; i++) begin
      vr[i] = 1200 * i - 3001;
      vi[i] = 777 - 515 * i;
      wr[i] = 23170;
      wi[i] = -23170 + 1000 * i;
      vc[i] = (i % 2) == 1;
      model(vr[i], vi[i], wr[i], wi[i], vc[i], er[i], ei[i]);
    end
    sent = 0;
    recv = 0;
    hold_v = 1'b0;
    hold_re = 0;
    hold_im = 0;
    for (int cyc = 0; cyc < 80 && recv < 8; cyc++) begin
      @(negedge clk_i);
      ready_i = (pat[cyc % 4] != 0);
      if (sent < 8) drive(vr[sent], vi[sent], wr[sent], wi[sent], vc[sent], 1'b1);
      else valid_i = 1'b0;
      #1;
      check("bp_ready_o", int'(ready_o), int'(!valid_o || ready_i));
      if (hold_v) begin
        check("bp_hold_valid", int'(valid_o), 1);
        check("bp_hold_re", int'($signed(x_re_o)), hold_re);
        check("bp_hold_im", int'($signed(x_im_o)), hold_im);
      end
      if (valid_o && ready_i) begin
        check("bp_re", int'($signed(x_re_o)), er[recv]);
        check("bp_im", int'($signed(x_im_o)), ei[recv]);
        recv++;
      end
      if (valid_i && ready_o) sent++;
      hold_v  = valid_o && !ready_i;
      hold_re = int'($signed(x_re_o));
      hold_im = int'($signed(x_im_o));
    end
    check("bp_recv_count", recv, 8);
    check("bp_sent_count", sent, 8);
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check("bp_no_dup", int'(valid_o), 0);
    end

    // Reset with three beats in flight (output stalled so none leaves).
    @(negedge clk_i);
    ready_i = 1'b0;
    drive(111, 222, 16384, 0, 1'b0, 1'b1);
    @(negedge clk_i);
    drive(333, 444, 16384, 0, 1'b0, 1'b1);
    @(negedge clk_i);
    drive(555, 666, 16384, 0, 1'b0, 1'b1);
    @(negedge clk_i);
    valid_i = 1'b0;
    #1;
    check("mid_full_valid", int'(valid_o), 1);
    check("mid_full_ready", int'(ready_o), 0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i   = 1'b0;
    ready_i = 1'b1;
    #1;
    check("mid_rst_valid", int'(valid_o), 0);
    check("mid_rst_ready", int'(ready_o), 1);
    check("mid_rst_x_re", int'($signed(x_re_o)), 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      check("mid_no_stale", int'(valid_o), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bel_cmul_pipe.md
Name: bel_cmul_pipe

Overview:
- Pipelined complex multiplier for the twiddle-factor stage of the FFT datapath.
- Computes x = a · w, where a is a complex sample and w is a twiddle in Q1.(tw_width-1).
- Sits directly upstream of the complex add/sub butterfly stage and feeds its b operand.
- Uses a valid/ready handshake with full-pipeline stall; an optional conjugate input supports the inverse transform.

Parameters:
- word_width, 16, sample width (a and x, two's complement).
- tw_width, 16, twiddle width (w, two's complement Q1.(tw_width-1)).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- a_re_i  in  word_width  sample, real part.
- a_im_i  in  word_width  sample, imaginary part.
- w_re_i  in  tw_width  twiddle, real part.
- w_im_i  in  tw_width  twiddle, imaginary part.
- conj_i  in  1  1 = multiply by conj(w).
- valid_i  in  1  input beat valid.
- ready_o  out  1  block can accept an input beat.
- x_re_o  out  word_width  product, real part.
- x_im_o  out  word_width  product, imaginary part.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts the output beat.

Behaviour:
- Clocking: one clock, clk_i. Reset is synchronous, active-high (rst_i).
- Pipeline: three register stages (S1 input capture, S2 products, S3 sum/round/limit). Each stage has a valid bit v1/v2/v3; valid_o = v3.
- Advance enable: en = !v3 || ready_i. ready_o = en, combinational from v3 and ready_i.
- Transfers: an input transfer occurs when valid_i && ready_o. An output transfer occurs when valid_o && ready_i.
- When en = 1, all stages shift: v1 <= valid_i, v2 <= v1, v3 <= v2, with data alongside.
- When en = 0, all stage registers and valid bits hold. Bubbles are not collapsed.
- Latency: 3 cycles from input transfer to valid_o with no stall. Throughput is 1 beat/cycle while ready_i = 1.
- S1: register a, w, conj and valid.
- S2: form four signed products pp_rr = a_re·w_re, pp_ii = a_im·w_im, pp_ri = a_re·w_im, pp_ir = a_im·w_re, each word_width+tw_width bits.
- S3, conj = 0: re = pp_rr − pp_ii, im = pp_ir + pp_ri.
- S3, conj = 1: re = pp_rr + pp_ii, im = pp_ir − pp_ri. The twiddle is never negated, so w_im = −2^(tw_width−1) is exact.
- Sums are word_width+tw_width+1 bits wide.
- Rounding: round half up, r = (sum + 2^(tw_width−2)) >>> (tw_width−1), arithmetic shift.
- r is then reduced to word_width bits per the optional feature.
- Reset: v1/v2/v3 <= 0 and all data registers <= 0. Hence valid_o = 0, x_re_o = 0, x_im_o = 0, and ready_o = 1 in the cycle after reset.
- Reset mid-operation discards all in-flight beats; no beat emerges afterwards.
- x_re_o/x_im_o are undefined-but-stable (hold the last S3 value) while valid_o = 0; the verifier checks them only when valid_o = 1.
- Simultaneous input and output transfer in the same cycle is legal and loses no data.
- valid_o stays asserted and the data holds stable until ready_i is seen high (AXI-stream rule). valid_i is not required to be held by the upstream.

Optional Feature:
- Macro: BEL_CMUL_SATURATE_EN.
- Defined: r is clamped to [−2^(word_width−1), 2^(word_width−1)−1].
- Undefined: r is truncated to its low word_width bits (two's-complement wrap). No extra logic is generated.

Test Plan:
- Scaling, W=T=16: a=(1000,0), w=(16384,0), conj=0 → x=(500,0). valid_o rises exactly 3 cycles after the input transfer.
- Complex product and conj: a=(1000,2000), w=(0,16384). conj=0 → x=(−1000,500); conj=1 → x=(1000,−500).
- Rounding: a=(3,−3), w=(16384,0) → x=(2,−1) (1.5→2, −1.5→−1).
- Corner case: a=(−32768,−32768), w=(−32768,−32768), conj=0 → re=0. im=32767 with BEL_CMUL_SATURATE_EN, im=0 without.
- Back-pressure: stream 8 beats with valid_i=1 while ready_i toggles 1,0,0,1,...
  - ready_o follows !v3 || ready_i.
  - All 8 results emerge in order, with none dropped or duplicated.
  - Output data stays stable while valid_o=1 and ready_i=0.
- Reset mid-stream: assert rst_i for 1 cycle with 3 beats in flight → valid_o=0 next cycle, no stale beat ever emerges, and ready_o=1.
